io_out_controller: RTL and testbench

Sequences the CPU's output I/O phase and buffers its results for an external consumer. Holds `startIO` low for a programmable start delay, then enables the CPU. Captures every word the CPU presents on `outFlag`/`out` into a small FIFO and drains it over a valid/ready interface. Finishes after a fixed number of outputs. Sits between the `CPU` top level and the board or bench consumer, replacing the ad-hoc `startIO` timing and `outFlag` polling.

---
 rtl/io_ctrl_pkg.sv | 17 +
 rtl/io_out_fifo.sv | 70 +++++++
 rtl/io_out_controller.sv | 139 +++++++++++++
 tb/tb_io_out_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared types and default parameters for the CPU output-phase controller.
package io_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RUN,
        DRAIN,
        DONE
    } io_state_t;

    localparam int DEF_WIDTH       = 24;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_START_DELAY = 30;
    localparam int DEF_OUT_COUNT   = 4;

endpackage

// File: rtl/io_out_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module io_out_fifo
    import io_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] headData
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign headData = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = pushData;
                wr_ptr_d                = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/io_out_controller.sv
// Sequences the CPU output phase: start delay, startIO enable, capture of CPU
// words into a FIFO drained over valid/ready, and completion after OUT_COUNT words.
module io_out_controller
    import io_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int START_DELAY = DEF_START_DELAY,
    parameter int OUT_COUNT   = DEF_OUT_COUNT
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             cpuOutFlag,
    input  logic [WIDTH-1:0]                 cpuOut,
    output logic                             startIO,
    output logic                             outValid,
    output logic [WIDTH-1:0]                 outData,
    input  logic                             outReady,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic [$clog2(OUT_COUNT+1)-1:0]   captured
);

    localparam int CW = $clog2(OUT_COUNT + 1);
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [DW-1:0] DLY_LAST = DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);

    io_state_t     state_q, state_d;
    logic [DW-1:0] dly_cnt_q, dly_cnt_d;
    logic [CW-1:0] cap_q, cap_d;
    logic          ovf_q, ovf_d;
    logic          start_io_q, start_io_d;

    logic fifo_push, fifo_flush, fifo_full, fifo_empty, pop_fire;

    assign pop_fire = !fifo_empty && outReady;

    io_out_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .pushData(cpuOut),
        .pop     (outReady),
        .flush   (fifo_flush),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .headData(outData)
    );

    always_comb begin
        state_d    = state_q;
        dly_cnt_d  = dly_cnt_q;
        cap_d      = cap_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        // Dropping enable leaves startIO low on the very next cycle.
        start_io_d = (state_q == RUN) && enable;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    cap_d     = '0;
                    ovf_d     = 1'b0;
                    dly_cnt_d = '0;
                    state_d   = (START_DELAY > 0) ? DELAY : RUN;
                end
            end
            DELAY: begin
                if (!enable) begin
                    state_d    = IDLE;
                    fifo_flush = 1'b1;
                end else if (dly_cnt_q == DLY_LAST) begin
                    state_d = RUN;
                end else begin
                    dly_cnt_d = dly_cnt_q + DW'(1);
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d    = IDLE;
                    fifo_flush = 1'b1;
                end else if (cpuOutFlag) begin
                    cap_d     = cap_q + CW'(1);
                    fifo_push = 1'b1;
                    if (fifo_full && !pop_fire) begin
                        ovf_d = 1'b1;
                    end
                    if (cap_d == CW'(OUT_COUNT)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!enable) begin
                    state_d    = IDLE;
                    fifo_flush = 1'b1;
                end else if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dly_cnt_q  <= '0;
            cap_q      <= '0;
            ovf_q      <= 1'b0;
            start_io_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
            cap_q      <= cap_d;
            ovf_q      <= ovf_d;
            start_io_q <= start_io_d;
        end
    end

    assign startIO  = start_io_q;
    assign outValid = !fifo_empty;
    assign busy     = (state_q == DELAY) || (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;
    assign captured = cap_q;

endmodule

// File: tb/tb_io_out_controller.sv
// Self-checking bench: vector table on a short-delay/6-output instance, directed
// sequences and randomized traffic against a queue-based model on the default one.
module tb_io_out_controller;

    localparam int W     = 24;
    localparam int DEPTH = 4;
    localparam int SD    = 30;
    localparam int OC    = 4;
    localparam int SD_B  = 2;
    localparam int OC_B  = 6;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         en_a  = 1'b0;
    logic         en_b  = 1'b0;
    logic         flag  = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] data  = '0;

    logic         sio_a, val_a, busy_a, done_a, ovf_a;
    logic [W-1:0] dat_a;
    logic [2:0]   cap_a;
    logic         sio_b, val_b, busy_b, done_b, ovf_b;
    logic [W-1:0] dat_b;
    logic [2:0]   cap_b;

    always #5 clock = ~clock;

    io_out_controller #(
        .WIDTH(W), .DEPTH(DEPTH), .START_DELAY(SD), .OUT_COUNT(OC)
    ) dut (
        .clock(clock), .reset(reset), .enable(en_a), .cpuOutFlag(flag), .cpuOut(data),
        .startIO(sio_a), .outValid(val_a), .outData(dat_a), .outReady(ready),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .captured(cap_a)
    );

    io_out_controller #(
        .WIDTH(W), .DEPTH(DEPTH), .START_DELAY(SD_B), .OUT_COUNT(OC_B)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(en_b), .cpuOutFlag(flag), .cpuOut(data),
        .startIO(sio_b), .outValid(val_b), .outData(dat_b), .outReady(ready),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .captured(cap_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model of the default instance ----------------
    localparam int P_IDLE = 0, P_DELAY = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;
    int           m_phase;
    int           m_left;
    int           m_cap;
    bit           m_ovf;
    bit           m_sio;
    logic [W-1:0] m_q[$];

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_left  = 0;
        m_cap   = 0;
        m_ovf   = 1'b0;
        m_sio   = 1'b0;
        m_q.delete();
    endfunction

    function automatic void model_edge(bit e, bit f, logic [W-1:0] d, bit r);
        bit pop = (m_q.size() > 0) && r;
        int nxt = m_phase;
        m_sio = (m_phase == P_RUN) && e;
        if (!e && (m_phase == P_DELAY || m_phase == P_RUN || m_phase == P_DRAIN)) begin
            nxt = P_IDLE;
            m_q.delete();
        end else begin
            case (m_phase)
                P_IDLE: if (e) begin
                    m_cap  = 0;
                    m_ovf  = 1'b0;
                    m_left = SD - 1;
                    nxt    = (SD > 0) ? P_DELAY : P_RUN;
                end
                P_DELAY: if (m_left == 0) nxt = P_RUN; else m_left--;
                P_RUN: begin
                    bit room = (m_q.size() < DEPTH) || pop;
                    if (pop) void'(m_q.pop_front());
                    if (f) begin
                        m_cap++;
                        if (room) m_q.push_back(d); else m_ovf = 1'b1;
                        if (m_cap == OC) nxt = P_DRAIN;
                    end
                end
                P_DRAIN: begin
                    bit was_empty = (m_q.size() == 0);
                    if (pop) void'(m_q.pop_front());
                    if (was_empty) nxt = P_DONE;
                end
                P_DONE: if (!e) nxt = P_IDLE;
                default: nxt = P_IDLE;
            endcase
        end
        m_phase = nxt;
    endfunction

    task automatic check_a(input string tag);
        check({tag, ".startIO"}, sio_a, m_sio);
        check({tag, ".outValid"}, val_a, m_q.size() > 0);
        if (m_q.size() > 0) check({tag, ".outData"}, dat_a, m_q[0]);
        check({tag, ".busy"}, busy_a,
              m_phase == P_DELAY || m_phase == P_RUN || m_phase == P_DRAIN);
        check({tag, ".done"}, done_a, m_phase == P_DONE);
        check({tag, ".overflow"}, ovf_a, m_ovf);
        check({tag, ".captured"}, cap_a, m_cap);
    endtask

    task automatic step(input string tag, input bit e, input bit f,
                        input logic [W-1:0] d, input bit r);
        en_a  = e;
        flag  = f;
        data  = d;
        ready = r;
        @(posedge clock);
        model_edge(e, f, d, r);
        #1;
        check_a(tag);
    endtask

    // ---------------- vector table for the second instance ----------------
    typedef struct {
        bit en, fl, rd;
        logic [W-1:0] d;
        bit sio, val;
        logic [W-1:0] dat;
        bit bsy, dn, ov;
        int cap;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t v(bit en, bit fl, int d, bit rd, bit sio, bit val, int dat,
                               bit bsy, bit dn, bit ov, int cap);
        vec_t x;
        x.en = en; x.fl = fl; x.d = W'(d); x.rd = rd;
        x.sio = sio; x.val = val; x.dat = W'(dat);
        x.bsy = bsy; x.dn = dn; x.ov = ov; x.cap = cap;
        return x;
    endfunction

    initial begin
        int rise;
        int words[4];

        // Run 1: fill to full, push with simultaneous pop, last word dropped, drain.
        tbl[0]  = v(1,0,0,0,       0,0,0,      1,0,0,0);
        tbl[1]  = v(1,0,0,0,       0,0,0,      1,0,0,0);
        tbl[2]  = v(1,0,0,0,       0,0,0,      1,0,0,0);
        tbl[3]  = v(1,1,'h11,0,    1,1,'h11,   1,0,0,1);
        tbl[4]  = v(1,1,'h22,0,    1,1,'h11,   1,0,0,2);
        tbl[5]  = v(1,1,'h33,0,    1,1,'h11,   1,0,0,3);
        tbl[6]  = v(1,1,'h44,0,    1,1,'h11,   1,0,0,4);
        tbl[7]  = v(1,1,'h55,1,    1,1,'h22,   1,0,0,5);
        tbl[8]  = v(1,1,'h66,0,    1,1,'h22,   1,0,1,6);
        tbl[9]  = v(1,0,0,0,       0,1,'h22,   1,0,1,6);
        tbl[10] = v(1,0,0,1,       0,1,'h33,   1,0,1,6);
        tbl[11] = v(1,0,0,1,       0,1,'h44,   1,0,1,6);
        tbl[12] = v(1,0,0,1,       0,1,'h55,   1,0,1,6);
        tbl[13] = v(1,0,0,1,       0,0,0,      1,0,1,6);
        tbl[14] = v(1,0,0,1,       0,0,0,      0,1,1,6);
        tbl[15] = v(0,0,0,0,       0,0,0,      0,0,1,6);
        // Run 2: 5 back-to-back words under back-pressure, then release.
        tbl[16] = v(1,0,0,0,       0,0,0,      1,0,0,0);
        tbl[17] = v(1,0,0,0,       0,0,0,      1,0,0,0);
        tbl[18] = v(1,0,0,0,       0,0,0,      1,0,0,0);
        tbl[19] = v(1,1,'hB1,0,    1,1,'hB1,   1,0,0,1);
        tbl[20] = v(1,1,'hB2,0,    1,1,'hB1,   1,0,0,2);
        tbl[21] = v(1,1,'hB3,0,    1,1,'hB1,   1,0,0,3);
        tbl[22] = v(1,1,'hB4,0,    1,1,'hB1,   1,0,0,4);
        tbl[23] = v(1,1,'hB5,0,    1,1,'hB1,   1,0,1,5);
        tbl[24] = v(1,0,0,1,       1,1,'hB2,   1,0,1,5);
        tbl[25] = v(1,0,0,1,       1,1,'hB3,   1,0,1,5);
        tbl[26] = v(1,0,0,1,       1,1,'hB4,   1,0,1,5);
        tbl[27] = v(1,0,0,1,       1,0,0,      1,0,1,5);
        tbl[28] = v(1,1,'hB6,1,    1,1,'hB6,   1,0,1,6);
        tbl[29] = v(1,0,0,1,       0,0,0,      1,0,1,6);
        tbl[30] = v(1,0,0,1,       0,0,0,      0,1,1,6);
        tbl[31] = v(0,0,0,0,       0,0,0,      0,0,1,6);

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst.startIO",  sio_a, 0);
        check("rst.outValid", val_a, 0);
        check("rst.outData",  dat_a, 0);
        check("rst.busy",     busy_a, 0);
        check("rst.done",     done_a, 0);
        check("rst.overflow", ovf_a, 0);
        check("rst.captured", cap_a, 0);
        check("rst_b.outData", dat_b, 0);
        check("rst_b.captured", cap_b, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            en_b  = tbl[i].en;
            flag  = tbl[i].fl;
            data  = tbl[i].d;
            ready = tbl[i].rd;
            @(posedge clock);
            #1;
            $display("vec %0d: en=%0d flag=%0d data=%0h ready=%0d -> startIO=%0d valid=%0d data=%0h cap=%0d ovf=%0d",
                     i, tbl[i].en, tbl[i].fl, tbl[i].d, tbl[i].rd, sio_b, val_b, dat_b, cap_b, ovf_b);
            check($sformatf("vec%0d.startIO", i), sio_b, tbl[i].sio);
            check($sformatf("vec%0d.outValid", i), val_b, tbl[i].val);
            if (tbl[i].val) check($sformatf("vec%0d.outData", i), dat_b, tbl[i].dat);
            check($sformatf("vec%0d.busy", i), busy_b, tbl[i].bsy);
            check($sformatf("vec%0d.done", i), done_b, tbl[i].dn);
            check($sformatf("vec%0d.overflow", i), ovf_b, tbl[i].ov);
            check($sformatf("vec%0d.captured", i), cap_b, tbl[i].cap);
        end
        en_b = 1'b0;

        // Start delay: startIO rises exactly SD+1 edges after enable is sampled.
        step("delay", 1, 0, '0, 0);
        check("delay.busy_e0", busy_a, 1);
        rise = -1;
        for (int k = 1; k <= SD + 5 && rise < 0; k++) begin
            step("delay", 1, 0, '0, 0);
            check("delay.busy", busy_a, 1);
            if (sio_a) rise = k;
        end
        check("delay.latency", rise, SD + 1);
        $display("start delay: startIO rose %0d edges after enable", rise);

        // Nominal run, words spaced 5 cycles apart, consumer always ready.
        words = '{90000, 180000, 80, 80};
        for (int i = 0; i < 4; i++) begin
            step("nominal", 1, 1, W'(words[i]), 1);
            check("nominal.valid", val_a, 1);
            check("nominal.word", dat_a, words[i]);
            $display("nominal: word %0d out=%0d captured=%0d", i, dat_a, cap_a);
            if (i < 3) repeat (4) step("nominal", 1, 0, '0, 1);
        end
        check("nominal.captured", cap_a, 4);
        for (int k = 0; k < 10 && !done_a; k++) step("nominal", 1, 0, '0, 1);
        check("nominal.done", done_a, 1);
        check("nominal.overflow", ovf_a, 0);
        step("nominal", 0, 0, '0, 1);

        // Abort with two words buffered, then re-arm.
        step("abort", 1, 0, '0, 0);
        for (int k = 0; k < SD + 5 && !sio_a; k++) step("abort", 1, 0, '0, 0);
        check("abort.in_run", sio_a, 1);
        step("abort", 1, 1, 24'h0A0A0A, 0);
        step("abort", 1, 1, 24'h0B0B0B, 0);
        check("abort.captured_pre", cap_a, 2);
        step("abort", 0, 0, '0, 0);
        check("abort.busy", busy_a, 0);
        check("abort.startIO", sio_a, 0);
        check("abort.outValid", val_a, 0);
        check("abort.captured_hold", cap_a, 2);
        step("abort", 1, 0, '0, 0);
        check("abort.captured_clear", cap_a, 0);
        check("abort.overflow_clear", ovf_a, 0);
        $display("abort: re-armed, captured=%0d busy=%0d", cap_a, busy_a);

        // Asynchronous reset between clock edges while in RUN.
        for (int k = 0; k < SD + 5 && !sio_a; k++) step("areset", 1, 0, '0, 0);
        step("areset", 1, 1, 24'h123456, 0);
        check("areset.pre_valid", val_a, 1);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check("areset.startIO",  sio_a, 0);
        check("areset.outValid", val_a, 0);
        check("areset.outData",  dat_a, 0);
        check("areset.busy",     busy_a, 0);
        check("areset.done",     done_a, 0);
        check("areset.overflow", ovf_a, 0);
        check("areset.captured", cap_a, 0);
        $display("async reset: outputs cleared before next edge");
        @(negedge clock);
        reset = 1'b1;

        // Randomized traffic against the model.
        begin
            int rp = 2;
            for (int c = 0; c < 4000; c++) begin
                bit e, f, r;
                if (c % 150 == 0) rp = $urandom_range(0, 4);
                e = ($urandom_range(0, 99) < 97);
                f = e ? 1'($urandom_range(0, 1)) : 1'b0;
                r = ($urandom_range(0, 3) < rp);
                step("rand", e, f, W'($urandom), r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
